// File: rtl/xup_sipo_nbit.sv
// xup_sipo_nbit: serial-in parallel-out word assembler with ready/valid output and sticky overrun.
// Define XUP_SIPO_PARITY_EN to append one even-parity bit to every word.
module xup_sipo_nbit #(
    parameter int SIZE  = 6,
    parameter int DELAY = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            serial_in,
    input  logic            serial_valid,
    input  logic            dir,
    input  logic            clear,
    output logic [SIZE-1:0] parallel_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            overrun,
    output logic            parity_err
);
    localparam int CW = $clog2(SIZE + 1);

    if (SIZE < 2 || SIZE > 32 || DELAY < 0) begin : g_bad_param
        $error("xup_sipo_nbit: SIZE must be 2..32 and DELAY non-negative");
    end

`ifdef XUP_SIPO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] sr_q, sr_d, pout_q, pout_d, sr_shift, word;
    logic            dir_q, dir_d, valid_q, valid_d, overrun_q, overrun_d, perr_q, perr_d;
    logic            dir_eff, last, done, perr_new;

    // The first bit of a word uses the live dir input; later bits use the latched copy.
    assign dir_eff  = (state_q == IDLE) ? dir : dir_q;
    assign sr_shift = dir_eff ? {serial_in, sr_q[SIZE-1:1]} : {sr_q[SIZE-2:0], serial_in};
    assign last     = cnt_q == CW'(SIZE - 1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        dir_d     = dir_q;
        pout_d    = pout_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        perr_d    = perr_q;
        done      = 1'b0;
        word      = sr_shift;
        perr_new  = 1'b0;
        if (valid_q && out_ready)
            valid_d = 1'b0;
        if (clear) begin
            state_d   = IDLE;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else if (serial_valid) begin
`ifdef XUP_SIPO_PARITY_EN
            if (state_q == PARITY) begin
                done     = 1'b1;
                word     = sr_q;
                perr_new = ^{sr_q, serial_in};
            end else begin
                sr_d    = sr_shift;
                cnt_d   = cnt_q + CW'(1);
                state_d = last ? PARITY : SHIFT;
                dir_d   = dir_eff;
            end
`else
            sr_d    = sr_shift;
            cnt_d   = cnt_q + CW'(1);
            state_d = SHIFT;
            dir_d   = dir_eff;
            done    = last;
`endif
            if (done) begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!valid_q || out_ready) begin
                    pout_d  = word;
                    valid_d = 1'b1;
                    perr_d  = perr_new;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            dir_q     <= 1'b0;
            pout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            dir_q     <= dir_d;
            pout_q    <= pout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
        end
    end

    assign parallel_out = pout_q;
    assign out_valid    = valid_q;
    assign overrun      = overrun_q;
    assign parity_err   = perr_q;
endmodule
